// File: rtl/beat_gen.sv
// Beat generator: one-hot PHASES-beat timing sequence, each beat DIV clocks long,
// with run / stop-at-cycle-end / single-step control and a machine-cycle counter.
module beat_gen #(
  parameter int PHASES = 4,
  parameter int DIV    = 25_000_000,
  parameter int CNT_W  = 8
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  output logic [PHASES-1:0] t,
  output logic              busy,
  output logic              cycle_end,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int              CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);
  localparam logic [PHASES-1:0] T_FIRST = PHASES'(1);

  typedef enum logic [1:0] {IDLE, RUN, STEP, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          last;
  logic          resume;
  logic          keep_running;

  assign busy         = (state != IDLE);
  assign tick         = busy && (cnt == CNT_MAX);
  assign last         = t[PHASES-1];
  assign cycle_end    = tick && last;
  assign resume       = (state == DRAIN) && start && !stop;
  // A cycle wraps to T[0] if we are running, or a drain is being cancelled this clock.
  assign keep_running = (state == RUN) || resume;

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      t         <= '0;
      cnt       <= '0;
      cycle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!stop && (start || step)) begin
            state <= start ? RUN : STEP;
            t     <= T_FIRST;
          end else begin
            t <= '0;
          end
        end
        default: begin
          cnt <= tick ? '0 : cnt + CW'(1);
          if (state == RUN && stop)
            state <= DRAIN;
          else if (resume)
            state <= RUN;
          if (tick) begin
            if (!last) begin
              t <= t << 1;
            end else begin
              cycle_cnt <= cycle_cnt + CNT_W'(1);
              if (keep_running) begin
                t <= T_FIRST;
              end else begin
                state <= IDLE;
                t     <= '0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beat_gen.sv
// Self-checking bench for beat_gen: directed scenarios plus random control pulses,
// compared against a position-in-cycle reference model.
module tb_beat_gen;

  localparam int P = 4;
  localparam int D = 3;
  localparam int L = P * D;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, step;
  logic [3:0] t;
  logic       busy, cycle_end;
  logic [7:0] cycle_cnt;

  logic       start2, stop2, step2;
  logic [1:0] t2;
  logic       busy2, ce2;
  logic [1:0] cc2;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: mode 0 idle, 1 run, 2 step, 3 drain; pos = clocks into the cycle
  int m_mode, m_pos, m_cnt;

  always #5 clk = ~clk;

  beat_gen #(.PHASES(4), .DIV(3), .CNT_W(8)) dut (
    .clk_100M(clk), .rst(rst), .start(start), .stop(stop), .step(step),
    .t(t), .busy(busy), .cycle_end(cycle_end), .cycle_cnt(cycle_cnt)
  );

  beat_gen #(.PHASES(2), .DIV(1), .CNT_W(2)) dut2 (
    .clk_100M(clk), .rst(rst), .start(start2), .stop(stop2), .step(step2),
    .t(t2), .busy(busy2), .cycle_end(ce2), .cycle_cnt(cc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic s, input logic p, input logic st);
    int nmode;
    if (m_mode == 0) begin
      if (!p && (s || st)) begin
        m_mode = s ? 1 : 2;
        m_pos  = 0;
      end
    end else begin
      nmode = m_mode;
      if (m_mode == 1 && p) nmode = 3;
      else if (m_mode == 3 && s && !p) nmode = 1;
      if (m_pos == L - 1) begin
        m_cnt = (m_cnt + 1) % 256;
        if (m_mode == 1 || nmode == 1) begin
          m_pos  = 0;
          m_mode = nmode;
        end else begin
          m_mode = 0;
          m_pos  = 0;
        end
      end else begin
        m_pos++;
        m_mode = nmode;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] et;
    et = (m_mode != 0) ? (32'd1 << (m_pos / D)) : 32'd0;
    chk("t", {28'd0, t}, et);
    chk("busy", {31'd0, busy}, (m_mode != 0) ? 32'd1 : 32'd0);
    chk("cycle_end", {31'd0, cycle_end}, (m_mode != 0 && m_pos == L - 1) ? 32'd1 : 32'd0);
    chk("cycle_cnt", {24'd0, cycle_cnt}, m_cnt);
    chk("onehot0", {31'd0, $onehot0(t)}, 32'd1);
  endtask

  task automatic cyc(input logic s, input logic p, input logic st);
    start = s; stop = p; step = st;
    @(posedge clk);
    model_edge(s, p, st);
    #1;
    start = 1'b0; stop = 1'b0; step = 1'b0;
    check_all();
  endtask

  initial begin
    int k, nce, nb, c0;
    rst = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
    start2 = 1'b0; stop2 = 1'b0; step2 = 1'b0;
    model_reset();
    #3;
    check_all();
    @(negedge clk) rst = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    // continuous run
    nce = 0;
    cyc(1, 0, 0);
    for (int i = 0; i < 30; i++) begin
      cyc(0, 0, 0);
      if (cycle_end) nce++;
    end
    chk("run_cnt", {24'd0, cycle_cnt}, 32'd2);
    chk("run_ce", nce, 32'd2);

    // stop while t=T[1]
    for (k = 0; k < 20 && !(m_mode == 1 && m_pos / D == 1); k++) cyc(0, 0, 0);
    chk("stop_wait", {31'd0, (m_mode == 1 && m_pos / D == 1)}, 32'd1);
    c0 = m_cnt;
    cyc(0, 1, 0);
    for (k = 0; k < 40 && m_mode != 0; k++) cyc(0, 0, 0);
    chk("stop_idle", {31'd0, busy}, 32'd0);
    chk("stop_cnt", {24'd0, cycle_cnt}, (c0 + 1) % 256);

    // single steps
    for (int r = 0; r < 2; r++) begin
      c0 = m_cnt;
      nb = 0;
      cyc(0, 0, 1);
      if (busy) nb++;
      for (int i = 0; i < 19; i++) begin
        cyc(0, 0, 0);
        if (busy) nb++;
      end
      chk("step_len", nb, L);
      chk("step_cnt", {24'd0, cycle_cnt}, (c0 + 1) % 256);
    end

    // simultaneous controls
    cyc(1, 1, 0);
    chk("startstop_idle", {31'd0, busy}, 32'd0);
    cyc(1, 0, 1);
    chk("startstep_run", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0);
    chk("startstep_still", {31'd0, busy}, 32'd1);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(0, 0, 0);
      if (busy) nb++;
    end
    chk("drain_resume", nb, 32'd30);
    cyc(0, 1, 0);
    for (k = 0; k < 40 && m_mode != 0; k++) cyc(0, 0, 0);
    chk("drain_idle", {31'd0, busy}, 32'd0);

    // asynchronous reset mid-run at t=T[2], cnt=1
    cyc(1, 0, 0);
    for (k = 0; k < 20 && m_pos != 2 * D + 1; k++) cyc(0, 0, 0);
    chk("rst_wait", {31'd0, (m_pos == 2 * D + 1)}, 32'd1);
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 rst = 1'b1;
    cyc(0, 0, 0);

    // random control pulses
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 31);
      cyc(r == 0 || r == 3, r == 1 || r == 3, r == 2 || r == 4);
    end
    for (k = 0; k < 40 && m_mode != 0; k++) cyc(0, 1, 0);
    chk("final_idle", {31'd0, busy}, 32'd0);

    // PHASES=2, DIV=1, CNT_W=2
    @(negedge clk) start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    for (int j = 0; j < 12; j++) begin
      chk("t2", {30'd0, t2}, (j % 2 == 0) ? 32'd1 : 32'd2);
      chk("ce2", {31'd0, ce2}, (j % 2 == 1) ? 32'd1 : 32'd0);
      chk("cc2", {30'd0, cc2}, (j / 2) % 4);
      chk("busy2", {31'd0, busy2}, 32'd1);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/beat_gen.md
# beat_gen

Parametrised beat (timing-signal) generator for the experiment CPU datapath. It produces a one-hot sequence of PHASES beat signals T[0]..T[PHASES-1], each held for DIV clocks of the 100 MHz board clock, which replaces a fixed 4-phase ring built from discrete flip-flops. Run, stop-at-cycle-end and single-step control come from debounced front-panel pulses. A machine-cycle counter and an end-of-cycle strobe feed the display and sequencing logic downstream.

## Interface
- PHASES, 4, number of beats per machine cycle; minimum 2.
- DIV, 25_000_000, board clocks per beat; minimum 1.
- CNT_W, 8, width of the machine-cycle counter.
- clk_100M  input  1  board clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-clock pulse; enter continuous run.
- stop  input  1  one-clock pulse; halt at the end of the current machine cycle.
- step  input  1  one-clock pulse; run exactly one machine cycle, then halt.
- t  output  PHASES  beat outputs; one-hot while busy, all zero when idle.
- busy  output  1  high in RUN, STEP or DRAIN.
- cycle_end  output  1  high during the last clock of beat T[PHASES-1].
- cycle_cnt  output  CNT_W  completed machine cycles, wraps modulo 2^CNT_W.

## Operation
- States:
  - IDLE: t=0, divider held at 0.
  - RUN: cycles repeat.
  - STEP: one cycle, then IDLE.
  - DRAIN: finish the current cycle, then IDLE.
- Divider: cnt counts 0..DIV-1 while busy. tick = busy & (cnt==DIV-1). On tick, cnt goes to 0.
- Beat advance: on tick, t rotates one position (T[i] to T[i+1]).
- Wrap at the last beat (tick with t[PHASES-1] set):
  - RUN: t becomes T[0].
  - STEP or DRAIN: go to IDLE, t=0.
  - All three cases: cycle_cnt increments.
- cycle_end = tick & t[PHASES-1], decoded from registers, no added delay.
- IDLE transitions:
  - start: RUN, t=T[0], cnt=0.
  - step without start: STEP, t=T[0], cnt=0.
  - stop present: stay IDLE; stop overrides start and step.
  - start together with step: start wins.
- RUN: stop goes to DRAIN; start and step are ignored.
- DRAIN: start without stop returns to RUN; the stop request is cancelled; beats are not disturbed.
- STEP: start, stop and step are ignored.
- A stop arriving in the same clock as the last-beat tick in RUN still goes to DRAIN. The cycle just completing wraps to T[0], so one further full cycle runs before IDLE.
- busy = (state != IDLE).

## Timing
- Reset (rst low, asynchronous): state IDLE, t=0, cnt=0, cycle_cnt=0, busy=0, cycle_end=0. Takes effect immediately, including mid-cycle.
- Latency: a start or step sampled at edge k gives t=T[0] and busy=1 after edge k.
- Beat length: each beat lasts exactly DIV clocks. A machine cycle lasts PHASES*DIV clocks.
- Step length: busy is high for exactly PHASES*DIV clocks per step.
- Last beat: cycle_end is high for one clock, the final clock of T[PHASES-1]. The edge that ends that clock increments cycle_cnt and returns to IDLE when applicable.
- DIV=1: t advances every clock, and cycle_end is high for the whole of T[PHASES-1].
- cycle_cnt: 2^CNT_W-1 wraps to 0 with no flag.
- t is never multi-hot in any state.

## Test plan
- Continuous run (PHASES=4, DIV=3): rst released, start pulse -> t sequence 1,1,1,2,2,2,4,4,4,8,8,8,1…; cycle_end pulses every 12 clocks; cycle_cnt 0→1→2.
- Single step (PHASES=4, DIV=3): step pulse -> busy high for 12 clocks, t returns to 0, cycle_cnt=1; a second step gives cycle_cnt=2.
- Stop mid-cycle (PHASES=4, DIV=3): stop while t=2 -> beats continue to the end of T[3], then IDLE; cycle_cnt incremented exactly once after the stop.
- Simultaneous controls:
  - start+stop in IDLE -> stays IDLE.
  - start+step in IDLE -> RUN.
  - start in DRAIN -> RUN, never leaves busy.
- Reset mid-run: rst low while t=4, cnt=1 -> t=0, busy=0, cycle_cnt=0 immediately, without waiting for a clock edge.
- Boundaries:
  - PHASES=2, DIV=1, CNT_W=2, run 5 cycles -> t alternates 1,2 every clock; cycle_cnt 1,2,3,0,1.
  - Check t is one-hot throughout the run.
